// File: rtl/fir_bank_mac_if.sv
// Sample/coefficient/result bundle for one FIR sub-filter bank.
// The bank drives the slave side; the sample source drives the master side.
interface fir_bank_mac_if #(
  parameter int BANK_LEN     = 6,
  parameter int INPUT_WIDTH  = 12,
  parameter int TAP_WIDTH    = 16,
  parameter int OUTPUT_WIDTH = 16
) ();
  localparam int IDX_W = (BANK_LEN > 1) ? $clog2(BANK_LEN) : 1;

  logic                           clear;
  logic signed [INPUT_WIDTH-1:0]  din;
  logic                           din_valid;
  logic                           din_ready;
  logic                           coef_we;
  logic [IDX_W-1:0]               coef_addr;
  logic signed [TAP_WIDTH-1:0]    coef_data;
  logic                           coef_ready;
  logic signed [OUTPUT_WIDTH-1:0] dout;
  logic                           dout_valid;
  logic                           dout_sat;

  modport master (
    output clear, din, din_valid, coef_we, coef_addr, coef_data,
    input  din_ready, coef_ready, dout, dout_valid, dout_sat
  );

  modport slave (
    input  clear, din, din_valid, coef_we, coef_addr, coef_data,
    output din_ready, coef_ready, dout, dout_valid, dout_sat
  );
endinterface

// File: rtl/fir_bank_mac.sv
// Polyphase FIR sub-filter bank: one shared multiplier walks the taps,
// then the accumulator is rounded, saturated and presented as a registered result.
module fir_bank_mac #(
  parameter int BANK_LEN     = 6,
  parameter int INPUT_WIDTH  = 12,
  parameter int TAP_WIDTH    = 16,
  parameter int ACC_WIDTH    = 31,
  parameter int OUTPUT_WIDTH = 16,
  parameter int OUT_SHIFT    = 15
) (
  input logic           clk,
  input logic           rst_n,
  fir_bank_mac_if.slave bus
);

  localparam int IDX_W  = (BANK_LEN > 1) ? $clog2(BANK_LEN) : 1;
  localparam int PROD_W = INPUT_WIDTH + TAP_WIDTH;
  localparam int RND_SH = (OUT_SHIFT > 0) ? (OUT_SHIFT - 1) : 0;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BANK_LEN - 1);
  localparam logic [IDX_W:0]   LEN_X    = (IDX_W + 1)'(BANK_LEN);

  // Rounding and clamp constants live one bit wider than the accumulator.
  localparam logic signed [ACC_WIDTH:0] ONE_X    = {{ACC_WIDTH{1'b0}}, 1'b1};
  localparam logic signed [ACC_WIDTH:0] RND_BIAS = (OUT_SHIFT > 0) ? (ONE_X <<< RND_SH) : '0;
  localparam logic signed [ACC_WIDTH:0] OUT_MAX  =
    {{(ACC_WIDTH + 2 - OUTPUT_WIDTH){1'b0}}, {(OUTPUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] OUT_MIN  =
    {{(ACC_WIDTH + 2 - OUTPUT_WIDTH){1'b1}}, {(OUTPUT_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t                         r_state;
  logic [IDX_W-1:0]               r_idx;
  logic signed [INPUT_WIDTH-1:0]  r_dline [BANK_LEN];
  logic signed [TAP_WIDTH-1:0]    r_coef  [BANK_LEN];
  logic signed [ACC_WIDTH-1:0]    r_acc;
  logic signed [OUTPUT_WIDTH-1:0] r_dout;
  logic                           r_dout_sat;
  logic                           r_dout_valid;
  logic                           r_ready;

  logic signed [PROD_W-1:0]       w_d_ext;
  logic signed [PROD_W-1:0]       w_c_ext;
  logic signed [PROD_W-1:0]       w_prod;
  logic signed [ACC_WIDTH-1:0]    w_prod_ext;
  logic signed [ACC_WIDTH:0]      w_acc_x;
  logic signed [ACC_WIDTH:0]      w_rounded;
  logic signed [OUTPUT_WIDTH-1:0] w_sat_val;
  logic                           w_sat_flag;
  logic                           w_accept;
  logic                           w_coef_wr;

  assign bus.din_ready  = r_ready;
  assign bus.coef_ready = r_ready;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.dout_sat   = r_dout_sat;

  // Tap product, accumulator rounding/clamping and handshake qualifiers.
  always_comb begin
    w_d_ext    = {{TAP_WIDTH{r_dline[r_idx][INPUT_WIDTH-1]}}, r_dline[r_idx]};
    w_c_ext    = {{INPUT_WIDTH{r_coef[r_idx][TAP_WIDTH-1]}}, r_coef[r_idx]};
    w_prod     = w_d_ext * w_c_ext;
    w_prod_ext = {{(ACC_WIDTH - PROD_W){w_prod[PROD_W-1]}}, w_prod};
    w_acc_x    = {r_acc[ACC_WIDTH-1], r_acc};
    w_rounded  = (w_acc_x + RND_BIAS) >>> OUT_SHIFT;
    w_sat_val  = w_rounded[OUTPUT_WIDTH-1:0];
    w_sat_flag = 1'b0;
    if (w_rounded > OUT_MAX) begin
      w_sat_val  = OUT_MAX[OUTPUT_WIDTH-1:0];
      w_sat_flag = 1'b1;
    end else if (w_rounded < OUT_MIN) begin
      w_sat_val  = OUT_MIN[OUTPUT_WIDTH-1:0];
      w_sat_flag = 1'b1;
    end else begin
      w_sat_flag = 1'b0;
    end
    w_accept  = bus.din_valid & r_ready;
    w_coef_wr = bus.coef_we & r_ready & ({1'b0, bus.coef_addr} < LEN_X);
  end

  // Control FSM together with delay line, coefficient store, accumulator and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_acc        <= '0;
      r_dout       <= '0;
      r_dout_sat   <= 1'b0;
      r_dout_valid <= 1'b0;
      r_ready      <= 1'b1;
      for (int k = 0; k < BANK_LEN; k++) begin
        r_dline[k] <= '0;
        r_coef[k]  <= '0;
      end
    end else if (bus.clear) begin
      // Flush wins over any handshake this cycle; result and taps are kept.
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_acc        <= '0;
      r_dout_valid <= 1'b0;
      r_ready      <= 1'b1;
      for (int k = 0; k < BANK_LEN; k++) begin
        r_dline[k] <= '0;
      end
    end else begin
      r_dout_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_coef_wr) begin
            r_coef[bus.coef_addr] <= bus.coef_data;
          end
          if (w_accept) begin
            r_dline[0] <= bus.din;
            for (int k = 1; k < BANK_LEN; k++) begin
              r_dline[k] <= r_dline[k-1];
            end
            r_acc   <= '0;
            r_idx   <= '0;
            r_ready <= 1'b0;
            r_state <= ST_MAC;
          end
        end
        ST_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            r_state <= ST_OUT;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_OUT: begin
          r_dout       <= w_sat_val;
          r_dout_sat   <= w_sat_flag;
          r_dout_valid <= 1'b1;
          r_ready      <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_idx   <= '0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
